// File: rtl/mm_cfg_pkg.sv
// Shared constants, command packing and FSM encoding for mm_cfg_master.
// Poll states are only present when MM_AUTOPOLL_EN is defined.
package mm_cfg_pkg;

   localparam logic [7:0] ADDR_CFG    = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h01;
   localparam logic [7:0] ADDR_ERRCNT = 8'h02;

   localparam int CMD_W = 41;

   typedef struct packed {
      logic        write;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WR_ISSUE   = 3'd1,
      RD_ISSUE   = 3'd2,
      RD_WAIT    = 3'd3,
      RESP       = 3'd4
`ifdef MM_AUTOPOLL_EN
      ,
      POLL_ISSUE = 3'd5,
      POLL_WAIT  = 3'd6
`endif
   } state_t;

   // Only the config register is writable; config, status and error counts are readable.
   function automatic logic cmd_legal(input cmd_t c);
      if (c.write) begin
         return (c.addr == ADDR_CFG);
      end else begin
         return (c.addr <= ADDR_ERRCNT);
      end
   endfunction

endpackage

// File: rtl/mm_cmd_fifo.sv
// Synchronous command FIFO with extra-bit wrap-around pointers. The ready flag is
// registered so it reads 0 while in reset and tracks !full afterwards.
module mm_cmd_fifo
   import mm_cfg_pkg::*;
#(
   parameter int CMD_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [CMD_W-1:0] din,
   output logic [CMD_W-1:0] dout,
   output logic             ready,
   output logic             empty
);
   localparam int AW = $clog2(CMD_DEPTH);

   logic [CMD_W-1:0] mem [CMD_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
   logic             do_push, do_pop, full_next;

   assign do_push = push && ready;
   assign do_pop  = pop && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_comb begin
      if (do_push) begin
         wr_ptr_next = wr_ptr + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_next = wr_ptr;
      end
      if (do_pop) begin
         rd_ptr_next = rd_ptr + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_next = rd_ptr;
      end
      full_next = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ready  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         ready  <= !full_next;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/mm_cfg_master.sv
// Register-bus initiator: queues host commands and issues each as one mm_* transaction.
// Define MM_AUTOPOLL_EN to add periodic polling of the status and error-count registers.
module mm_cfg_master
   import mm_cfg_pkg::*;
#(
   parameter int CMD_DEPTH   = 4,
   parameter int RD_LATENCY  = 1,
   parameter int POLL_PERIOD = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [7:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_write,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mm_write_en,
   output logic        mm_read_en,
   output logic [7:0]  mm_addr,
   output logic [31:0] mm_wdata,
   input  logic [31:0] mm_rdata,
   output logic [1:0]  status_active_channel,
   output logic [3:0]  status_signal_present,
   output logic [31:0] status_err_counts,
   output logic        status_update
);
   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mm_cfg_master: CMD_DEPTH must be a power of two >= 2");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
      $error("mm_cfg_master: RD_LATENCY must be 1..3");
   end
   if (POLL_PERIOD < 2) begin : g_bad_period
      $error("mm_cfg_master: POLL_PERIOD must be >= 2");
   end

   state_t           state, state_next;
   logic [CMD_W-1:0] fifo_dout;
   cmd_t             head;
   logic             fifo_empty, pop, head_legal, lat_done, issue_rd, in_wait;
   logic [1:0]       lat_cnt;

   mm_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .pop   (pop),
      .din   ({cmd_write, cmd_addr, cmd_wdata}),
      .dout  (fifo_dout),
      .ready (cmd_ready),
      .empty (fifo_empty)
   );

   assign head       = cmd_t'(fifo_dout);
   assign head_legal = cmd_legal(head);
   assign lat_done   = (lat_cnt == 2'(RD_LATENCY));

`ifdef MM_AUTOPOLL_EN
   localparam int PW = $clog2(POLL_PERIOD);

   logic [PW-1:0] poll_cnt;
   logic [5:0]    poll_status;
   logic          poll_pending, poll_second, poll_capture, poll_start, poll_next;

   assign poll_start   = (state == IDLE) && (state_next == POLL_ISSUE);
   assign poll_next    = (state == POLL_WAIT) && (state_next == POLL_ISSUE);
   assign poll_capture = (state == POLL_WAIT) && lat_done;
   assign issue_rd     = (state_next == RD_ISSUE) || (state_next == POLL_ISSUE);
   assign in_wait      = (state == RD_WAIT) || (state == POLL_WAIT);
`else
   assign issue_rd     = (state_next == RD_ISSUE);
   assign in_wait      = (state == RD_WAIT);
`endif

   // Next-state decode; queued host commands always win over a pending poll.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (!head_legal) begin
                  state_next = RESP;
               end else if (head.write) begin
                  state_next = WR_ISSUE;
               end else begin
                  state_next = RD_ISSUE;
               end
            end
`ifdef MM_AUTOPOLL_EN
            else if (poll_pending) begin
               state_next = POLL_ISSUE;
            end
`endif
            else begin
               state_next = IDLE;
            end
         end
         WR_ISSUE: state_next = RESP;
         RD_ISSUE: state_next = RD_WAIT;
         RD_WAIT: begin
            if (lat_done) begin
               state_next = RESP;
            end else begin
               state_next = RD_WAIT;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end else begin
               state_next = RESP;
            end
         end
`ifdef MM_AUTOPOLL_EN
         POLL_ISSUE: state_next = POLL_WAIT;
         POLL_WAIT: begin
            if (!lat_done) begin
               state_next = POLL_WAIT;
            end else if (poll_second) begin
               state_next = IDLE;
            end else begin
               state_next = POLL_ISSUE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // State register plus bus and response outputs, all registered off the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         lat_cnt     <= 2'd1;
         mm_write_en <= 1'b0;
         mm_read_en  <= 1'b0;
         mm_addr     <= 8'h00;
         mm_wdata    <= 32'h0000_0000;
         resp_valid  <= 1'b0;
         resp_write  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= 32'h0000_0000;
      end else begin
         state       <= state_next;
         mm_write_en <= (state_next == WR_ISSUE);
         mm_read_en  <= issue_rd;
         resp_valid  <= (state_next == RESP);
         if (in_wait) begin
            lat_cnt <= lat_cnt + 2'd1;
         end else begin
            lat_cnt <= 2'd1;
         end
         // Illegal commands leave the bus address/data untouched.
         if (pop && head_legal) begin
            mm_addr <= head.addr;
            if (head.write) begin
               mm_wdata <= head.wdata;
            end
         end
`ifdef MM_AUTOPOLL_EN
         else if (poll_start) begin
            mm_addr <= ADDR_STATUS;
         end else if (poll_next) begin
            mm_addr <= ADDR_ERRCNT;
         end
`endif
         if (pop) begin
            resp_write <= head.write;
            resp_err   <= !head_legal;
            resp_rdata <= 32'h0000_0000;
         end else if ((state == RD_WAIT) && lat_done) begin
            resp_rdata <= mm_rdata;
         end
      end
   end

`ifdef MM_AUTOPOLL_EN
   // Poll timer, two-read sequencing and status refresh after the second capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         poll_cnt              <= '0;
         poll_pending          <= 1'b0;
         poll_second           <= 1'b0;
         poll_status           <= 6'd0;
         status_active_channel <= 2'd0;
         status_signal_present <= 4'd0;
         status_err_counts     <= 32'h0000_0000;
         status_update         <= 1'b0;
      end else begin
         status_update <= poll_capture && poll_second;
         if (poll_cnt == PW'(POLL_PERIOD - 1)) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b1;
         end else begin
            poll_cnt <= poll_cnt + PW'(1);
            if (poll_capture && poll_second) begin
               poll_pending <= 1'b0;
            end
         end
         if (poll_start) begin
            poll_second <= 1'b0;
         end else if (poll_capture) begin
            poll_second <= 1'b1;
         end
         if (poll_capture && !poll_second) begin
            poll_status <= mm_rdata[5:0];
         end
         if (poll_capture && poll_second) begin
            status_active_channel <= poll_status[1:0];
            status_signal_present <= poll_status[5:2];
            status_err_counts     <= mm_rdata;
         end
      end
   end
`else
   assign status_active_channel = 2'd0;
   assign status_signal_present = 4'd0;
   assign status_err_counts     = 32'h0000_0000;
   assign status_update         = 1'b0;
`endif

endmodule
